// File: rtl/display_digit_loader.sv
// ---------------------------------------------------------------------------
// display_digit_loader
//
// Upstream feeder for the seven-segment display driver. Bytes arrive from the
// UART receive path over a valid/ready handshake and are paired up as
// {high byte, low byte} into a 16-bit word. The word is shown as four held
// hex digits. The block also produces the 5 ms multiplex strobe from the
// 1 MHz system clock. A half-received word times out after TIMEOUT_PULSES
// strobes. Parity errors and timeouts are counted.
//
// Parameters
//   PULSE_PERIOD    CLK cycles per PULSE_5MS strobe
//   TIMEOUT_PULSES  strobes allowed between high and low byte
//
// Ports
//   CLK           in   system clock (1 MHz nominal)
//   RESET         in   asynchronous, active-high reset
//   BYTE_IN       in   received byte
//   BYTE_VALID    in   BYTE_IN valid (transfer on BYTE_VALID & BYTE_READY)
//   BYTE_PERR     in   parity error flag, qualified by BYTE_VALID
//   BYTE_READY    out  loader can accept a byte
//   PULSE_5MS     out  one-cycle strobe every PULSE_PERIOD cycles
//   DIGIT_0..3    out  held digits, {DIGIT_3..DIGIT_0} = {high, low}
//   WORD_UPDATED  out  one-cycle pulse when a new word is committed
//   ERROR_COUNT   out  saturating count of parity errors and timeouts
// ---------------------------------------------------------------------------
module display_digit_loader #(
    parameter int PULSE_PERIOD   = 5000,
    parameter int TIMEOUT_PULSES = 200
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] BYTE_IN,
    input  logic       BYTE_VALID,
    input  logic       BYTE_PERR,
    output logic       BYTE_READY,
    output logic       PULSE_5MS,
    output logic [3:0] DIGIT_0,
    output logic [3:0] DIGIT_1,
    output logic [3:0] DIGIT_2,
    output logic [3:0] DIGIT_3,
    output logic       WORD_UPDATED,
    output logic [7:0] ERROR_COUNT
);

    localparam int PW = (PULSE_PERIOD > 1) ? $clog2(PULSE_PERIOD) : 1;
    localparam int TW = (TIMEOUT_PULSES > 1) ? $clog2(TIMEOUT_PULSES + 1) : 1;

    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_PERIOD - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_PULSES - 1);

    typedef enum logic [1:0] {
        WAIT_HI = 2'd0,
        WAIT_LO = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Timebase: free-running, never stalled by the handshake.
    // -----------------------------------------------------------------------
    logic [PW-1:0] tb_cnt_q;
    logic          pulse_q;

    // NOTE: state is written with non-blocking assignments only, so every
    // register samples the values from before the edge regardless of the
    // order of statements or blocks.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tb_cnt_q <= '0;
            pulse_q  <= 1'b0;
        end else begin
            pulse_q  <= (tb_cnt_q == PULSE_LAST);
            tb_cnt_q <= (tb_cnt_q == PULSE_LAST) ? '0 : tb_cnt_q + PW'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Byte assembly state machine
    // -----------------------------------------------------------------------
    state_t        state_q;
    logic          ready_q;
    logic [7:0]    hi_q;
    logic [7:0]    lo_q;
    logic [15:0]   digits_q;
    logic          word_updated_q;
    logic [TW-1:0] tmo_cnt_q;
    logic [7:0]    err_q;
    logic [7:0]    err_d;

    logic xfer;
    logic tmo_expire;
    logic err_event;

    assign xfer       = BYTE_VALID & ready_q;
    assign tmo_expire = pulse_q & (tmo_cnt_q == TMO_LAST);

    // A byte arriving on the expiry cycle takes priority over the timeout,
    // so a parity error coinciding with expiry still counts only once.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        err_event = 1'b0;
        err_d     = err_q;
        case (state_q)
            WAIT_HI: err_event = xfer & BYTE_PERR;
            WAIT_LO: err_event = xfer ? BYTE_PERR : tmo_expire;
            default: err_event = 1'b0;
        endcase
        // Saturate at 8'hFF instead of wrapping.
        if (err_event && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q        <= WAIT_HI;
            ready_q        <= 1'b0;
            hi_q           <= 8'h00;
            lo_q           <= 8'h00;
            digits_q       <= 16'h0000;
            word_updated_q <= 1'b0;
            tmo_cnt_q      <= '0;
            err_q          <= 8'h00;
        end else begin
            // BYTE_READY tracks the next state: low only while in COMMIT.
            ready_q        <= 1'b1;
            word_updated_q <= 1'b0;
            err_q          <= err_d;

            case (state_q)
                WAIT_HI: begin
                    if (xfer && !BYTE_PERR) begin
                        hi_q      <= BYTE_IN;
                        tmo_cnt_q <= '0;
                        state_q   <= WAIT_LO;
                    end
                end

                WAIT_LO: begin
                    if (xfer) begin
                        if (BYTE_PERR) begin
                            state_q <= WAIT_HI;
                        end else begin
                            lo_q    <= BYTE_IN;
                            state_q <= COMMIT;
                            ready_q <= 1'b0;
                        end
                    end else if (pulse_q) begin
                        if (tmo_expire) begin
                            state_q <= WAIT_HI;
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + TW'(1);
                        end
                    end
                end

                COMMIT: begin
                    digits_q       <= {hi_q, lo_q};
                    word_updated_q <= 1'b1;
                    state_q        <= WAIT_HI;
                end

                default: begin
                    state_q <= WAIT_HI;
                end
            endcase
        end
    end

    assign BYTE_READY   = ready_q;
    assign PULSE_5MS    = pulse_q;
    assign DIGIT_3      = digits_q[15:12];
    assign DIGIT_2      = digits_q[11:8];
    assign DIGIT_1      = digits_q[7:4];
    assign DIGIT_0      = digits_q[3:0];
    assign WORD_UPDATED = word_updated_q;
    assign ERROR_COUNT  = err_q;

endmodule

// File: tb/tb_display_digit_loader.sv
// ---------------------------------------------------------------------------
// tb_display_digit_loader
//
// Self-checking bench for display_digit_loader (PULSE_PERIOD 5000,
// TIMEOUT_PULSES 3). Inputs are driven and outputs sampled on the falling
// clock edge. Committed words are pushed to a scoreboard queue when the low
// byte is sent and popped when WORD_UPDATED is seen.
// ---------------------------------------------------------------------------
module tb_display_digit_loader;

    localparam int P = 5000;
    localparam int T = 3;

    logic       CLK;
    logic       RESET;
    logic [7:0] BYTE_IN;
    logic       BYTE_VALID;
    logic       BYTE_PERR;
    logic       BYTE_READY;
    logic       PULSE_5MS;
    logic [3:0] DIGIT_0;
    logic [3:0] DIGIT_1;
    logic [3:0] DIGIT_2;
    logic [3:0] DIGIT_3;
    logic       WORD_UPDATED;
    logic [7:0] ERROR_COUNT;

    logic [15:0] dig;
    assign dig = {DIGIT_3, DIGIT_2, DIGIT_1, DIGIT_0};

    display_digit_loader #(
        .PULSE_PERIOD  (P),
        .TIMEOUT_PULSES(T)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .BYTE_IN     (BYTE_IN),
        .BYTE_VALID  (BYTE_VALID),
        .BYTE_PERR   (BYTE_PERR),
        .BYTE_READY  (BYTE_READY),
        .PULSE_5MS   (PULSE_5MS),
        .DIGIT_0     (DIGIT_0),
        .DIGIT_1     (DIGIT_1),
        .DIGIT_2     (DIGIT_2),
        .DIGIT_3     (DIGIT_3),
        .WORD_UPDATED(WORD_UPDATED),
        .ERROR_COUNT (ERROR_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Rising edges since the last reset release.
    int edge_cnt;
    always @(posedge CLK or posedge RESET) begin
        if (RESET) edge_cnt <= 0;
        else       edge_cnt <= edge_cnt + 1;
    end

    logic [15:0] sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every WORD_UPDATED must match the oldest expected word.
    always @(negedge CLK) begin
        if (WORD_UPDATED === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_word_updated", {16'h0, dig}, 32'hDEAD_BEEF);
            end else begin
                check("sb_word", {16'h0, dig}, {16'h0, sb.pop_front()});
            end
        end
    end

    // Called on a falling edge; returns on the falling edge after the transfer.
    task automatic send_byte(input logic [7:0] b, input logic perr);
        logic took;
        logic done;
        done       = 1'b0;
        BYTE_IN    = b;
        BYTE_PERR  = perr;
        BYTE_VALID = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            took = BYTE_READY;
            @(negedge CLK);
            if (took) done = 1'b1;
        end
        BYTE_VALID = 1'b0;
        BYTE_PERR  = 1'b0;
        check("xfer_wait", {31'h0, done}, 32'h1);
    endtask

    // Returns on the falling edge where PULSE_5MS is high (may be the current one).
    task automatic wait_pulse();
        logic found;
        found = 1'b0;
        for (int i = 0; i < P + 10 && !found; i++) begin
            if (PULSE_5MS === 1'b1) found = 1'b1;
            else @(negedge CLK);
        end
        check("pulse_wait", {31'h0, found}, 32'h1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, {31'h0, BYTE_READY},   32'h0);
        check({tag, "_pulse"}, {31'h0, PULSE_5MS},    32'h0);
        check({tag, "_digits"}, {16'h0, dig},         32'h0);
        check({tag, "_wu"},    {31'h0, WORD_UPDATED}, 32'h0);
        check({tag, "_err"},   {24'h0, ERROR_COUNT},  32'h0);
    endtask

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic        lo_perr;
        logic [15:0] exp_digits;
        logic [7:0]  exp_err;
    } vec_t;

    vec_t vec[6];
    logic [7:0] exp_err;

    initial begin
        vec[0] = '{8'h34, 8'h56, 1'b1, 16'h12AB, 8'd1};
        vec[1] = '{8'h78, 8'h9A, 1'b0, 16'h789A, 8'd1};
        vec[2] = '{8'h00, 8'h00, 1'b0, 16'h0000, 8'd1};
        vec[3] = '{8'hFF, 8'hFF, 1'b0, 16'hFFFF, 8'd1};
        vec[4] = '{8'hA5, 8'h5A, 1'b1, 16'hFFFF, 8'd2};
        vec[5] = '{8'hC3, 8'h3C, 1'b0, 16'hC33C, 8'd2};

        RESET      = 1'b1;
        BYTE_IN    = 8'h00;
        BYTE_VALID = 1'b0;
        BYTE_PERR  = 1'b0;

        // ---- reset and timebase ------------------------------------------
        repeat (3) @(negedge CLK);
        check_reset_values("in_reset");
        RESET = 1'b0;
        check("ready_after_release", {31'h0, BYTE_READY}, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            wait_pulse();
            check($sformatf("pulse%0d_edge", k), edge_cnt, k * P);
            @(negedge CLK);
            check($sformatf("pulse%0d_width", k), {31'h0, PULSE_5MS}, 32'h0);
        end
        check("idle_digits", {16'h0, dig}, 32'h0);
        check("idle_err", {24'h0, ERROR_COUNT}, 32'h0);

        // ---- back-to-back word with cycle-exact timing -------------------
        send_byte(8'h12, 1'b0);
        sb.push_back(16'h12AB);
        send_byte(8'hAB, 1'b0);
        check("commit_ready_low", {31'h0, BYTE_READY}, 32'h0);
        check("commit_wu_low", {31'h0, WORD_UPDATED}, 32'h0);
        check("commit_digits_old", {16'h0, dig}, 32'h0);
        @(negedge CLK);
        check("upd_digits", {16'h0, dig}, 32'h12AB);
        check("upd_wu_high", {31'h0, WORD_UPDATED}, 32'h1);
        check("upd_ready_high", {31'h0, BYTE_READY}, 32'h1);
        @(negedge CLK);
        check("upd_wu_single", {31'h0, WORD_UPDATED}, 32'h0);

        // ---- table-driven words and low-byte parity errors ----------------
        for (int i = 0; i < 6; i++) begin
            if (!vec[i].lo_perr) sb.push_back({vec[i].hi, vec[i].lo});
            send_byte(vec[i].hi, 1'b0);
            send_byte(vec[i].lo, vec[i].lo_perr);
            @(negedge CLK);
            @(negedge CLK);
            check($sformatf("vec%0d_digits", i), {16'h0, dig}, {16'h0, vec[i].exp_digits});
            check($sformatf("vec%0d_err", i), {24'h0, ERROR_COUNT}, {24'h0, vec[i].exp_err});
            check($sformatf("vec%0d_ready", i), {31'h0, BYTE_READY}, 32'h1);
        end
        exp_err = 8'd2;

        // ---- timeout of a half word ---------------------------------------
        send_byte(8'hCD, 1'b0);
        wait_pulse(); @(negedge CLK);
        wait_pulse(); @(negedge CLK);
        wait_pulse();
        check("tmo_err_before", {24'h0, ERROR_COUNT}, {24'h0, exp_err});
        @(negedge CLK);
        exp_err = exp_err + 8'd1;
        check("tmo_err_after", {24'h0, ERROR_COUNT}, {24'h0, exp_err});
        check("tmo_digits_held", {16'h0, dig}, 32'hC33C);
        sb.push_back(16'hEF01);
        send_byte(8'hEF, 1'b0);
        send_byte(8'h01, 1'b0);
        @(negedge CLK); @(negedge CLK);
        check("tmo_next_word", {16'h0, dig}, 32'hEF01);

        // ---- valid low byte on the expiry cycle ----------------------------
        send_byte(8'h11, 1'b0);
        wait_pulse(); @(negedge CLK);
        wait_pulse(); @(negedge CLK);
        wait_pulse();
        sb.push_back(16'h1122);
        send_byte(8'h22, 1'b0);
        @(negedge CLK); @(negedge CLK);
        check("race_ok_digits", {16'h0, dig}, 32'h1122);
        check("race_ok_err", {24'h0, ERROR_COUNT}, {24'h0, exp_err});

        // ---- parity-error low byte on the expiry cycle ---------------------
        send_byte(8'h44, 1'b0);
        wait_pulse(); @(negedge CLK);
        wait_pulse(); @(negedge CLK);
        wait_pulse();
        send_byte(8'h55, 1'b1);
        @(negedge CLK); @(negedge CLK);
        exp_err = exp_err + 8'd1;
        check("race_perr_err", {24'h0, ERROR_COUNT}, {24'h0, exp_err});
        check("race_perr_digits", {16'h0, dig}, 32'h1122);
        check("race_perr_ready", {31'h0, BYTE_READY}, 32'h1);

        // ---- saturation ----------------------------------------------------
        for (int i = 0; i < 300; i++) begin
            send_byte(8'(i), 1'b1);
            exp_err = (exp_err == 8'hFF) ? 8'hFF : exp_err + 8'd1;
            if (i == 250 || i == 251) begin
                @(negedge CLK);
                check($sformatf("sat_err_%0d", i), {24'h0, ERROR_COUNT}, {24'h0, exp_err});
            end
        end
        @(negedge CLK);
        check("sat_err_hold", {24'h0, ERROR_COUNT}, 32'hFF);
        check("sat_digits_held", {16'h0, dig}, 32'h1122);

        // ---- asynchronous reset mid-word -----------------------------------
        send_byte(8'h66, 1'b0);
        RESET = 1'b1;
        #1;
        check_reset_values("rst_midword");
        @(negedge CLK);
        RESET = 1'b0;

        // ---- asynchronous reset in COMMIT ----------------------------------
        send_byte(8'h77, 1'b0);
        send_byte(8'h88, 1'b0);
        check("pre_rst_commit_ready", {31'h0, BYTE_READY}, 32'h0);
        RESET = 1'b1;
        #1;
        check_reset_values("rst_commit");
        @(negedge CLK);
        @(negedge CLK);
        check("rst_commit_no_update", {16'h0, dig}, 32'h0);
        RESET = 1'b0;

        sb.push_back(16'h99AA);
        send_byte(8'h99, 1'b0);
        send_byte(8'hAA, 1'b0);
        @(negedge CLK); @(negedge CLK); @(negedge CLK);
        check("post_rst_digits", {16'h0, dig}, 32'h99AA);
        check("post_rst_err", {24'h0, ERROR_COUNT}, 32'h0);
        check("sb_drained", sb.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
